poly_inverse_solver: RTL and testbench

POLY_INVERSE_SOLVER -- requirements
Module: poly_inverse_solver

---
 rtl/poly_inverse_solver.sv | 126 ++++++++++++
 tb/tb_poly_inverse_solver.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/poly_inverse_solver.sv
// Brute-force inverter for F(x,y,z) = 5x^2+8x-4y^2+3y+6z^2-2z+13 over x,y,z in 0..15.
// Optional POLY_SOLVER_COUNT_EN: full scan with a total match count on match_count.
module poly_inverse_solver (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [18:0] target,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [3:0]  out0,
    output logic [3:0]  out1,
    output logic [3:0]  out2
`ifdef POLY_SOLVER_COUNT_EN
    ,
    output logic [12:0] match_count
`endif
);

    // state  | meaning
    // IDLE   | waiting for start; results from the last search are held
    // SEARCH | one candidate {x,y,z} = idx compared per clock
    // DONE   | one-cycle completion, done is high
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t state, state_next;

    logic [11:0]        idx;
    logic [18:0]        target_q;
    logic signed [13:0] xs, ys, zs, f_val;
    logic [18:0]        f_ext;
    logic               is_match;
    logic               last;

    assign xs = {10'd0, idx[11:8]};
    assign ys = {10'd0, idx[7:4]};
    assign zs = {10'd0, idx[3:0]};

    // 14 signed bits comfortably hold -842..2578 and every intermediate product
    assign f_val = 14'sd5 * xs * xs + 14'sd8 * xs
                 - 14'sd4 * ys * ys + 14'sd3 * ys
                 + 14'sd6 * zs * zs - 14'sd2 * zs + 14'sd13;
    assign f_ext    = {{5{f_val[13]}}, f_val};
    assign is_match = (f_ext == target_q);
    assign last     = (idx == 12'hFFF);
    assign busy     = (state == SEARCH) || (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start) state_next = SEARCH;
`ifdef POLY_SOLVER_COUNT_EN
            SEARCH: if (last) state_next = DONE;
`else
            SEARCH: if (is_match || last) state_next = DONE;
`endif
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx      <= 12'd0;
            target_q <= 19'd0;
            done     <= 1'b0;
            found    <= 1'b0;
            out0     <= 4'd0;
            out1     <= 4'd0;
            out2     <= 4'd0;
`ifdef POLY_SOLVER_COUNT_EN
            match_count <= 13'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        target_q <= target;
                        idx      <= 12'd0;
                        found    <= 1'b0;
                        out0     <= 4'd0;
                        out1     <= 4'd0;
                        out2     <= 4'd0;
`ifdef POLY_SOLVER_COUNT_EN
                        match_count <= 13'd0;
`endif
                    end
                end
                SEARCH: begin
                    if (!last) idx <= idx + 12'd1;
`ifdef POLY_SOLVER_COUNT_EN
                    if (is_match) begin
                        match_count <= match_count + 13'd1;
                        // only the first (lowest-index) match is reported
                        if (!found) begin
                            found <= 1'b1;
                            out0  <= idx[11:8];
                            out1  <= idx[7:4];
                            out2  <= idx[3:0];
                        end
                    end
                    done <= last;
`else
                    if (is_match) begin
                        found <= 1'b1;
                        out0  <= idx[11:8];
                        out1  <= idx[7:4];
                        out2  <= idx[3:0];
                        done  <= 1'b1;
                    end else if (last) begin
                        done <= 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_inverse_solver.sv
// Directed-vector bench for poly_inverse_solver; expectations hand-derived from F(x,y,z).
// Also valid with POLY_SOLVER_COUNT_EN defined (full-scan latency and match counts).
module tb_poly_inverse_solver;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [18:0] target;
    logic        busy, done, found;
    logic [3:0]  out0, out1, out2;
`ifdef POLY_SOLVER_COUNT_EN
    logic [12:0] match_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    poly_inverse_solver dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .target (target),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .out0   (out0),
        .out1   (out1),
        .out2   (out2)
`ifdef POLY_SOLVER_COUNT_EN
        ,
        .match_count (match_count)
`endif
    );

    task automatic chk(input string tag, input int obs, input int exp_val);
        checks++;
        if (obs != exp_val) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_val);
        end
    endtask

    function automatic int lat(input int l);
`ifdef POLY_SOLVER_COUNT_EN
        return 4096;
`else
        return l;
`endif
    endfunction

    task automatic launch(input int t);
        @(negedge clk);
        start  = 1'b1;
        target = 19'(t);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // edges counts clocks until done is seen; busy_cyc counts busy periods before done
    task automatic wait_done(output int edges, output int busy_cyc);
        edges    = 0;
        busy_cyc = busy ? 1 : 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
            if (busy && !done) busy_cyc++;
        end while (!done && edges < 5000);
    endtask

    task automatic run_case(input string tag, input int t, input int exp_lat,
                            input int ef, input int ex, input int ey, input int ez);
        int e, bc;
        launch(t);
        wait_done(e, bc);
        chk({tag, "_lat"}, e, lat(exp_lat));
        chk({tag, "_found"}, int'(found), ef);
        chk({tag, "_x"}, int'(out0), ex);
        chk({tag, "_y"}, int'(out1), ey);
        chk({tag, "_z"}, int'(out2), ez);
        @(posedge clk);
        #1;
        chk({tag, "_done_fall"}, int'(done), 0);
        chk({tag, "_found_hold"}, int'(found), ef);
    endtask

    initial begin
        int e, bc, e1, e2;
        rst    = 1'b0;
        start  = 1'b0;
        target = 19'd0;
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_found", int'(found), 0);
        chk("rst_outs", int'({out0, out1, out2}), 0);
`ifdef POLY_SOLVER_COUNT_EN
        chk("rst_count", int'(match_count), 0);
`endif
        @(negedge clk);
        rst = 1'b1;

        run_case("t13", 13, 1, 1, 0, 0, 0);
        run_case("t17", 17, 2, 1, 0, 0, 1);
        run_case("t33", 33, 3, 1, 0, 0, 2);
        run_case("t12", 12, 17, 1, 0, 1, 0);
        run_case("tmin", -842, 241, 1, 0, 15, 0);
`ifdef POLY_SOLVER_COUNT_EN
        chk("tmin_count", int'(match_count), 1);
`endif
        run_case("tmax", 2578, 3856, 1, 15, 0, 15);
`ifdef POLY_SOLVER_COUNT_EN
        chk("tmax_count", int'(match_count), 1);
`endif

        // unreachable target: full scan, busy throughout
        launch(3000);
        chk("nomatch_busy_start", int'(busy), 1);
        wait_done(e, bc);
        chk("nomatch_lat", e, 4096);
        chk("nomatch_busy_cyc", bc, 4096);
        chk("nomatch_busy_at_done", int'(busy), 1);
        chk("nomatch_found", int'(found), 0);
        chk("nomatch_outs", int'({out0, out1, out2}), 0);
`ifdef POLY_SOLVER_COUNT_EN
        chk("nomatch_count", int'(match_count), 0);
`endif
        @(posedge clk);
        #1;
        chk("nomatch_idle", int'(busy), 0);

        // a start pulse mid-search with another target must be ignored
        launch(-842);
        repeat (10) @(posedge clk);
        @(negedge clk);
        start  = 1'b1;
        target = 19'd13;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(e, bc);
        chk("ignore_lat", e + 11, lat(241));
        chk("ignore_y", int'(out1), 15);
        @(posedge clk);

        // start held high relaunches on the first IDLE edge after DONE
        @(negedge clk);
        start  = 1'b1;
        target = 19'd17;
        @(posedge clk);
        #1;
        wait_done(e1, bc);
        chk("hold_lat1", e1, lat(2));
        wait_done(e2, bc);
        chk("hold_lat2", e2, lat(2) + 2);
        chk("hold_z", int'(out2), 1);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("hold_idle", int'(busy), 0);

        // asynchronous reset mid-search
        launch(2578);
        repeat (99) @(posedge clk);
        @(posedge clk);
        #2;
        chk("midrst_busy_before", int'(busy), 1);
        rst = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_found", int'(found), 0);
        chk("midrst_outs", int'({out0, out1, out2}), 0);
`ifdef POLY_SOLVER_COUNT_EN
        chk("midrst_count", int'(match_count), 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        run_case("restart", 13, 1, 1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
